// File: rtl/uart_reg_loader.sv
// rtl/uart_reg_loader.sv - UART address/data byte-pair loader into a flat register bank
// Define PARITY_EN for 8E1 framing; the default build is 8N1.
module uart_reg_loader #(
  parameter int OSCRATE  = 12_000_000,
  parameter int BAUDRATE = 9600,
  parameter int REGS     = 16,
  parameter int LINK_MS  = 50
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx,
  output logic [REGS*8-1:0]       reg_bus,
  output logic                    wr_stb,
  output logic [$clog2(REGS)-1:0] wr_addr,
  output logic                    frame_err,
  output logic                    link,
  output logic                    blink
);

  localparam int AW         = $clog2(REGS);
  localparam int BIT_CYC    = OSCRATE / BAUDRATE;
  localparam int HALF_CYC   = BIT_CYC / 2;
  localparam int CW         = $clog2(BIT_CYC + 1);
  localparam int LINK_CYC   = (LINK_MS * OSCRATE) / 1000;
  localparam int LW         = (LINK_CYC > 0) ? $clog2(LINK_CYC + 1) : 1;
  localparam int BLINK_HALF = OSCRATE / 2;
  localparam int BW         = $clog2(BLINK_HALF);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef PARITY_EN
    S_PAR,
`endif
    S_STOP
  } rx_state_e;

  typedef enum logic {
    P_ADDR,
    P_DATA
  } parse_state_e;

  logic          rx_s1_q, rx_s2_q, rx_s3_q;
  logic          rx_fall;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tick;
  logic          byte_vld_q, byte_vld_d;
  logic          frame_bad;
  logic          frame_err_q;
`ifdef PARITY_EN
  logic          par_err_q, par_err_d;
`endif

  parse_state_e  pstate_q, pstate_d;
  logic [AW-1:0] pend_q, pend_d;
  logic          addr_hit;
  logic          latch_en;
  logic          wr_en;
  logic [7:0]    bank_q [REGS];
  logic [AW-1:0] wr_addr_q;
  logic          wr_stb_q;
  logic [LW-1:0] link_cnt_q;
  logic [BW-1:0] div_q;
  logic          blink_q;

  // Third flop only feeds the falling-edge detector; the synchronised value is rx_s2_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end

  assign rx_fall = rx_s3_q & ~rx_s2_q;
  assign tick    = (cnt_q == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (rx_fall) state_d = S_START;
      S_START: if (tick) state_d = rx_s2_q ? S_IDLE : S_DATA;
      S_DATA: begin
        if (tick && bit_q == 3'd7) begin
`ifdef PARITY_EN
          state_d = S_PAR;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef PARITY_EN
      S_PAR:   if (tick) state_d = S_STOP;
`endif
      S_STOP:  if (tick) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte_vld_d = 1'b0;
    frame_bad  = 1'b0;
`ifdef PARITY_EN
    par_err_d  = par_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (rx_fall) cnt_d = CW'(HALF_CYC);
      end
      S_START: begin
        bit_d = 3'd0;
`ifdef PARITY_EN
        par_err_d = 1'b0;
`endif
        cnt_d = tick ? CW'(BIT_CYC) : cnt_q - CW'(1);
      end
      S_DATA: begin
        if (tick) begin
          shift_d = {rx_s2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          cnt_d   = CW'(BIT_CYC);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`ifdef PARITY_EN
      S_PAR: begin
        if (tick) begin
          par_err_d = ^{shift_q, rx_s2_q};
          cnt_d     = CW'(BIT_CYC);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
`ifdef PARITY_EN
          if (rx_s2_q && !par_err_q) byte_vld_d = 1'b1;
          else                       frame_bad  = 1'b1;
`else
          if (rx_s2_q) byte_vld_d = 1'b1;
          else         frame_bad  = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      byte_vld_q  <= byte_vld_d;
      frame_err_q <= frame_err_q | frame_bad;
`ifdef PARITY_EN
      par_err_q   <= par_err_d;
`endif
    end
  end

  // shift_q is stable while byte_vld_q is high: the FSM is in IDLE/START then.
  assign addr_hit = shift_q[7] && ((shift_q[6:0] >> AW) == 7'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      pstate_q <= P_ADDR;
    end else begin
      pstate_q <= pstate_d;
    end
  end

  always_comb begin
    pstate_d = pstate_q;
    if (frame_bad) begin
      pstate_d = P_ADDR;
    end else if (byte_vld_q) begin
      case (pstate_q)
        P_ADDR:  if (addr_hit) pstate_d = P_DATA;
        P_DATA:  pstate_d = P_ADDR;
        default: pstate_d = P_ADDR;
      endcase
    end
  end

  always_comb begin
    latch_en = byte_vld_q && (pstate_q == P_ADDR) && addr_hit;
    wr_en    = byte_vld_q && (pstate_q == P_DATA);
    pend_d   = latch_en ? shift_q[AW-1:0] : pend_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q    <= '0;
      wr_addr_q <= '0;
      wr_stb_q  <= 1'b0;
      for (int i = 0; i < REGS; i++) bank_q[i] <= '0;
    end else begin
      pend_q   <= pend_d;
      wr_stb_q <= wr_en;
      if (wr_en) begin
        bank_q[pend_q] <= shift_q;
        wr_addr_q      <= pend_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      link_cnt_q <= '0;
    end else if (byte_vld_q) begin
      link_cnt_q <= LW'(LINK_CYC);
    end else if (link_cnt_q != '0) begin
      link_cnt_q <= link_cnt_q - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      blink_q <= 1'b0;
    end else if (div_q == BW'(BLINK_HALF - 1)) begin
      div_q   <= '0;
      blink_q <= ~blink_q;
    end else begin
      div_q <= div_q + BW'(1);
    end
  end

  always_comb begin
    reg_bus = '0;
    for (int i = 0; i < REGS; i++) reg_bus[i*8 +: 8] = bank_q[i];
  end

  assign wr_stb    = wr_stb_q;
  assign wr_addr   = wr_addr_q;
  assign frame_err = frame_err_q;
  assign link      = (link_cnt_q != '0);
  assign blink     = blink_q;

endmodule
